// File: rtl/sram_lsu_bridge.sv
// Load/store bridge from the core memory stage to a single-port word-addressed SRAM.
// One request at a time: IDLE -> ACCESS (sel/ack handshake) -> RESP -> IDLE.
module sram_lsu_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  mem_sel,
  output logic                  mem_we,
  output logic [3:0]            mem_byte_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              be_q;
  logic [31:0]             din_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [1:0]              lane_q;
  logic [31:0]             rdata_q;
  logic                    accept;
  logic                    bad_req;
  logic                    capture;
  logic                    in_access;

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_en = 4'b0001 << lo;
      2'b01:   lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   store_rep = {4{w[7:0]}};
      2'b01:   store_rep = {2{w[15:0]}};
      default: store_rep = w;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] d);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    b  = 8'(d >> {lane, 3'b000});
    h  = lane[1] ? d[31:16] : d[15:0];
    bs = b;
    hs = h;
    case (size)
      2'b00:   load_fmt = uns ? {24'd0, b} : 32'(bs);
      2'b01:   load_fmt = uns ? {16'd0, h} : 32'(hs);
      default: load_fmt = d;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign bad_req   = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            first_d = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        // an ack on the timeout edge still completes the access cleanly
        if (mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TMO) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr >> 2;
      be_q    <= lane_en(req_size, req_addr[1:0]);
      din_q   <= store_rep(req_size, req_wdata);
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      lane_q  <= req_addr[1:0];
      rdata_q <= 32'd0;
    end else if (capture) begin
      rdata_q <= we_q ? 32'd0 : load_fmt(size_q, uns_q, lane_q, mem_dout);
    end
  end

  // outputs decode straight from state so reset drops sel/we without waiting for a clock
  assign in_access   = (state_q == ACCESS);
  assign mem_sel     = in_access;
  assign mem_we      = in_access & first_q & we_q;
  assign mem_byte_en = in_access ? be_q : 4'd0;
  assign mem_addr    = in_access ? addr_q : '0;
  assign mem_din     = in_access ? din_q : 32'd0;
  assign resp_valid  = (state_q == RESP);
  assign resp_err    = resp_valid & err_q;
  assign resp_rdata  = resp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Bench for sram_lsu_bridge: directed vector table, ack/timeout/reset corner sequences,
// and randomized traffic checked against a byte-level memory model.
module tb_sram_lsu_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_sel, mem_we;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'd0;
  logic        mem_ack  = 1'b0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sram_lsu_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_byte_en(mem_byte_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  // SRAM: acks ack_delay cycles after first sampling sel (1 = nominal part)
  logic [31:0] sram [256] = '{default: 32'h0};
  int  seen_n    = 0;
  bit  ack_en    = 1'b1;
  int  ack_delay = 1;
  bit  force_ack = 1'b0;

  always @(posedge clk) begin : sram_model
    logic [31:0] w;
    if (mem_sel) begin
      w = sram[mem_addr[7:0]];
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_byte_en[k]) w[8*k +: 8] = mem_din[8*k +: 8];
        sram[mem_addr[7:0]] <= w;
      end
      mem_dout <= sram[mem_addr[7:0]];
      mem_ack  <= force_ack | (ack_en && (seen_n == ack_delay - 1));
      seen_n   <= seen_n + 1;
    end else begin
      mem_ack <= force_ack;
      seen_n  <= 0;
    end
  end

  // Reference memory, byte-granular arithmetic view
  bit [31:0] ref_mem [256] = '{default: 32'h0};

  function automatic int nbytes(input bit [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit ref_err(input bit [1:0] size, input bit [31:0] addr);
    if (size == 2'd3) return 1'b1;
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic bit [31:0] ref_load(input bit [1:0] size, input bit uns, input bit [31:0] addr);
    longint word, v, one;
    int off, n;
    one  = 1;
    word = longint'(ref_mem[(addr >> 2) & 255]);
    off  = int'(addr % 4);
    n    = nbytes(size);
    v    = (word >> (8 * off)) & ((one << (8 * n)) - 1);
    if (!uns && n < 4 && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
    return v[31:0];
  endfunction

  function automatic bit [3:0] ref_be(input bit [1:0] size, input bit [31:0] addr);
    int v;
    v = ((1 << nbytes(size)) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic bit [31:0] ref_din(input bit [1:0] size, input bit [31:0] w);
    if (size == 2'd0) return {24'd0, w[7:0]} * 32'h01010101;
    if (size == 2'd1) return {16'd0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  task automatic ref_store(input bit [1:0] size, input bit [31:0] addr, input bit [31:0] w);
    int off, idx;
    off = int'(addr % 4);
    idx = int'((addr >> 2) & 255);
    for (int k = 0; k < nbytes(size); k++)
      ref_mem[idx][8 * (off + k) +: 8] = w[8 * k +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns what was observed through the response
  task automatic run_req(input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         output int lat, output bit err, output bit [31:0] rdata,
                         output int sel_n, output int we_n, output bit [3:0] be0,
                         output bit [31:0] din0, output bit [31:0] maddr0,
                         output bit stable, output bit after_ok);
    lat = -1; err = 0; rdata = 0; sel_n = 0; we_n = 0;
    be0 = 0; din0 = 0; maddr0 = 0; stable = 1; after_ok = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (mem_sel) begin
        if (sel_n == 0) begin
          be0 = mem_byte_en; din0 = mem_din; maddr0 = mem_addr;
        end else if (be0 != mem_byte_en || din0 != mem_din || maddr0 != mem_addr) begin
          stable = 0;
        end
        sel_n++;
      end
      if (mem_we) we_n++;
      if (resp_valid) begin
        lat = i; err = resp_err; rdata = resp_rdata;
      end
      @(negedge clk);
    end
    after_ok = (lat >= 0) && !resp_valid && req_ready && !mem_sel;
  endtask

  task automatic check_txn(input string nm, input bit we, input bit [1:0] size, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wdata,
                           input bit exp_err, input bit [31:0] exp_rdata, input bit [3:0] exp_be,
                           input bit [31:0] exp_din, input int exp_lat, input int exp_sel);
    int lat, sel_n, we_n;
    bit err, stable, after_ok;
    bit [31:0] rdata, din0, maddr0;
    bit [3:0] be0;
    check({nm, ".ready_in"}, req_ready, 1);
    run_req(we, size, uns, addr, wdata, lat, err, rdata, sel_n, we_n, be0, din0, maddr0,
            stable, after_ok);
    check({nm, ".latency"}, lat, exp_lat);
    check({nm, ".err"}, err, exp_err);
    check({nm, ".rdata"}, rdata, exp_rdata);
    check({nm, ".sel_cycles"}, sel_n, exp_sel);
    check({nm, ".we_cycles"}, we_n, (we && exp_sel > 0) ? 1 : 0);
    check({nm, ".ready_after"}, after_ok, 1);
    if (exp_sel > 0) begin
      check({nm, ".byte_en"}, be0, exp_be);
      check({nm, ".mem_addr"}, maddr0, addr >> 2);
      check({nm, ".stable"}, stable, 1);
      if (we) check({nm, ".mem_din"}, din0, exp_din);
    end
    if (we && !exp_err) ref_store(size, addr, wdata);
  endtask

  typedef struct {
    string     name;
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        exp_err;
    bit [31:0] exp_rdata;
    bit [3:0]  exp_be;
    bit [31:0] exp_din;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        ok;
    bit [1:0]  sz;
    bit [31:0] ad, wd;
    bit        we, un, e;
    int        lt;

    vecs[0]  = '{"sw_word",  1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[1]  = '{"lw_word",  0, 2'd2, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[2]  = '{"sb_3",     1, 2'd0, 0, 32'h103, 32'h80,       0, 32'h0,        4'h8, 32'h80808080};
    vecs[3]  = '{"lb_3",     0, 2'd0, 0, 32'h103, 32'h0,        0, 32'hFFFFFF80, 4'h8, 32'h0};
    vecs[4]  = '{"lbu_3",    0, 2'd0, 1, 32'h103, 32'h0,        0, 32'h00000080, 4'h8, 32'h0};
    vecs[5]  = '{"lh_2",     0, 2'd1, 0, 32'h102, 32'h0,        0, 32'hFFFF80AD, 4'hC, 32'h0};
    vecs[6]  = '{"lhu_0",    0, 2'd1, 1, 32'h100, 32'h0,        0, 32'h0000BEEF, 4'h3, 32'h0};
    vecs[7]  = '{"lh_0",     0, 2'd1, 0, 32'h100, 32'h0,        0, 32'hFFFFBEEF, 4'h3, 32'h0};
    vecs[8]  = '{"lw_mis",   0, 2'd2, 0, 32'h102, 32'h0,        1, 32'h0,        4'h0, 32'h0};
    vecs[9]  = '{"sh_mis",   1, 2'd1, 0, 32'h101, 32'h1234,     1, 32'h0,        4'h0, 32'h0};
    vecs[10] = '{"size_ill", 0, 2'd3, 0, 32'h100, 32'h0,        1, 32'h0,        4'h0, 32'h0};
    vecs[11] = '{"lw_uns",   0, 2'd2, 1, 32'h100, 32'h0,        0, 32'h80ADBEEF, 4'hF, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset.ready", req_ready, 0);
    check("reset.resp_valid", resp_valid, 0);
    check("reset.resp_err", resp_err, 0);
    check("reset.resp_rdata", resp_rdata, 0);
    check("reset.mem_sel", mem_sel, 0);
    check("reset.mem_we", mem_we, 0);
    check("reset.mem_outs", {mem_byte_en, mem_addr[27:0]} | mem_din, 0);
    rst = 1'b0;
    #1 check("reset.ready_release", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      check_txn(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_be,
                vecs[i].exp_din, vecs[i].exp_err ? 0 : 2, vecs[i].exp_err ? 0 : 2);

    ack_en = 1'b0;
    check_txn("timeout", 0, 2'd2, 0, 32'h100, 32'h0, 1, 32'h0, 4'hF, 32'h0, TMO, TMO);
    ack_en = 1'b1;

    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_sel || !req_ready) ok = 1'b0;
    end
    check("late_ack_ignored", ok, 1);

    ack_delay = TMO - 1;
    check_txn("ack_at_timeout", 0, 2'd2, 0, 32'h100, 32'h0, 0, ref_load(2'd2, 0, 32'h100),
              4'hF, 32'h0, TMO, TMO);
    ack_delay = 1;

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 1023);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~(nbytes(sz) - 1);
      we = 1'($urandom); un = 1'($urandom); wd = $urandom;
      e  = ref_err(sz, ad);
      lt = e ? 0 : 2;
      check_txn($sformatf("rand%0d", i), we, sz, un, ad, wd, e,
                (e || we) ? 32'h0 : ref_load(sz, un, ad), ref_be(sz, ad), ref_din(sz, wd), lt, lt);
    end

    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.sel_before", mem_sel, 1);
    check("abort.we_before", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    check("abort.sel_drop", mem_sel, 0);
    check("abort.we_drop", mem_we, 0);
    check("abort.ready_in_rst", req_ready, 0);
    ok = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 if (resp_valid || mem_sel) ok = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort.ready_release", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b0;
    end
    check("abort.no_resp", ok, 1);
    check_txn("abort.lw_after", 0, 2'd2, 0, 32'h200, 32'h0, 0, ref_load(2'd2, 0, 32'h200),
              4'hF, 32'h0, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sram_lsu_bridge.md
# sram_lsu_bridge

Load/store bridge between the core's memory stage and the single-port word-addressed data SRAM. It accepts one byte, halfword or word request at a time. It converts the byte address to a word address, generates byte enables, replicates store data across lanes, and runs the SRAM sel/ack handshake. It returns sign- or zero-extended load data, flags misaligned and timed-out accesses, and holds off the core with `req_ready` while busy.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte-address width of `req_addr`; `mem_addr` carries the word address in the same width.
- `TIMEOUT`, 15: maximum ACCESS cycles to wait for `mem_ack`, range 1..255.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge idle; a request is accepted on an edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: misaligned, illegal size or timeout; qualified by `resp_valid`.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `mem_sel`, `mem_we` out 1: SRAM select and write strobe.
- `mem_byte_en` out 4: SRAM lane enables.
- `mem_addr` out ADDR_WIDTH: equals `req_addr >> 2`.
- `mem_din` out 32: SRAM write data.
- `mem_dout` in 32: SRAM read data, valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: SRAM acknowledge.

## Operation
States:
- **IDLE:** `req_ready`=1, all `mem_*` outputs 0.
- **ACCESS:** `mem_sel`=1. `mem_addr`, `mem_byte_en` and `mem_din` are registered at accept and held stable. `mem_we` is high only in the first ACCESS cycle.
- **RESP:** `resp_valid`=1 for exactly one cycle; `mem_sel`=0, which gives the SRAM its required sel-low gap.

Transitions:
- IDLE→ACCESS on accept of an aligned, legal request.
- IDLE→RESP on accept of a misaligned or illegal request: `resp_err`=1, no SRAM activity.
- ACCESS→RESP when `mem_ack` is sampled high. `mem_dout` is captured and formatted on that same edge.
- ACCESS→RESP with `resp_err`=1 when the wait counter reaches TIMEOUT without an ack.
- RESP→IDLE unconditionally.

Misalignment rules:
- Half with `addr[0]`=1 is misaligned.
- Word with `addr[1:0]`≠0 is misaligned.
- Size 11 is always illegal.

Byte enables:
- Byte: `1 << addr[1:0]`.
- Half: 0011 if `addr[1]`=0, else 1100.
- Word: 1111.
- For loads, `mem_byte_en` is driven the same way; the SRAM ignores it.

Store data:
- Byte: `{4{wdata[7:0]}}`.
- Half: `{2{wdata[15:0]}}`.
- Word: `wdata` unchanged.

Load formatting:
- Byte: lane `addr[1:0]` is shifted to bits [7:0].
- Half: lane `addr[1]` is shifted to bits [15:0].
- Sign- or zero-extend to 32 bits per `req_unsigned`.
- `req_unsigned` is ignored for word loads.

Other rules:
- `mem_ack` is ignored in IDLE and RESP.
- `req_*` inputs are don't-care outside the accept edge; the bridge latches everything it needs.
- Reset mid-operation aborts the access. `mem_sel` and `mem_we` drop asynchronously, and no `resp_valid` is issued for the aborted request.

## Timing
- Reset values: `req_ready`=0 while `rst` is high and 1 in the first cycle after release. All other outputs are 0. State is IDLE and the wait counter is 0.
- SRAM protocol: the SRAM raises `mem_ack` for one cycle, one cycle after it first samples `mem_sel` high. `mem_sel` must be low for at least one cycle between accesses.
- Nominal access, with the accept edge as E0:
  - ACCESS during E0–E2.
  - `mem_ack` is high in the cycle after E1.
  - RESP, with `resp_valid` and data, in the cycle after E2.
  - `req_ready` returns in the cycle after E3.
- Throughput: one access per 4 cycles.
- Error response: `resp_valid` in the cycle after E0; `req_ready` high again in the cycle after E1.
- Timeout: the counter clears on entry to ACCESS and increments each ACCESS cycle without an ack. RESP with error follows TIMEOUT ACCESS cycles.
- If ack and the timeout coincide on the same edge, ack wins and `resp_err`=0.

## Test plan
- **Word store/load:** SW `addr`=0x100, `wdata`=0xDEADBEEF → `mem_addr`=0x40, `mem_byte_en`=1111, `mem_we` high for 1 cycle, `resp_valid` at E0+2 with `resp_err`=0. LW 0x100 → `resp_rdata`=0xDEADBEEF.
- **Byte store:** SB 0x103, `wdata`=0x80 → `mem_byte_en`=1000, `mem_din`=0x80808080.
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
- **Halfword loads:** memory word holds 0x80ADBEEF.
  - LH 0x102 → 0xFFFF80AD.
  - LHU 0x100 → 0x0000BEEF.
  - LH 0x100 → 0xFFFFBEEF.
- **Misaligned and illegal:** LW 0x102, SH 0x101, `size`=11 → `mem_sel` never rises; `resp_valid` with `resp_err`=1 and `resp_rdata`=0 at E0+1.
- **Timeout:** SRAM model never acks, TIMEOUT=4 → RESP with `resp_err`=1 after 4 ACCESS cycles. A late `mem_ack` in IDLE is ignored.
- **Reset mid-access:** assert `rst` during ACCESS → `mem_sel` and `mem_we` go 0 immediately and no `resp_valid` is issued. After release, a new LW completes normally.
